// File: rtl/flu_ctrl_sequencer.sv
// Issue stage for the FLU controller: replays a host-loaded program of control words,
// holding each for HOLD_CYCLES clocks and capturing the controller's output per word.
module flu_ctrl_sequencer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   result_in,
  output logic [31:0]   control,
  output logic          busy,
  output logic [AW-1:0] issue_idx,
  output logic          result_valid,
  output logic [31:0]   result,
  output logic          done
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CntLoad = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [AW:0]     len;
  logic [31:0]     mem [DEPTH];

  logic [AW:0]     start_len;
  logic [AW-1:0]   next_idx;
  logic            last_word;

  assign start_len = (prog_len > DepthLen) ? DepthLen : prog_len;
  assign next_idx  = issue_idx + AW'(1);
  assign last_word = ({1'b0, issue_idx} == (len - (AW + 1)'(1)));

  // Program memory is deliberately not reset; writes are locked out while a run is active
  // so a run always sees the program as it was at start.
  always_ff @(posedge clock) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StIdle;
      control      <= '0;
      busy         <= 1'b0;
      issue_idx    <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      done         <= 1'b0;
      cnt          <= '0;
      len          <= '0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (start_len == '0) begin
              done <= 1'b1;
            end else begin
              control   <= mem[0];
              issue_idx <= '0;
              cnt       <= CntLoad;
              busy      <= 1'b1;
              len       <= start_len;
              state     <= StRun;
            end
          end
        end
        StRun: begin
          // Abort wins over a coincident capture edge: nothing is reported for the cut word.
          if (abort) begin
            control   <= '0;
            busy      <= 1'b0;
            issue_idx <= '0;
            cnt       <= '0;
            state     <= StIdle;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            result       <= result_in;
            result_valid <= 1'b1;
            if (last_word) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= StIdle;
            end else begin
              issue_idx <= next_idx;
              control   <= mem[next_idx];
              cnt       <= CntLoad;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_flu_ctrl_sequencer.sv
// Directed bench for flu_ctrl_sequencer: a HOLD_CYCLES=10 instance for the main runs and a
// HOLD_CYCLES=1 instance for the clamp / back-to-back case. The controller is modelled as ~control.
module tb_flu_ctrl_sequencer;

  localparam int Depth = 16;
  localparam int Aw    = 4;
  localparam int Hold  = 10;

  typedef struct {
    logic [31:0] word;
    logic [31:0] resp;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [Aw-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [Aw:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          start1 = 1'b0;
  logic          abort = 1'b0;

  logic [31:0]   result_in, control, result;
  logic          busy, result_valid, done;
  logic [Aw-1:0] issue_idx;

  logic [31:0]   result_in1, control1, result1;
  logic          busy1, result_valid1, done1;
  logic [Aw-1:0] issue_idx1;

  int checks = 0;
  int errors = 0;
  vec_t prog [4];
  logic [31:0] words16 [16];

  assign result_in  = ~control;
  assign result_in1 = ~control1;

  always #5 clock = ~clock;

  flu_ctrl_sequencer #(.DEPTH(Depth), .AW(Aw), .HOLD_CYCLES(Hold)) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start), .abort(abort), .result_in(result_in),
    .control(control), .busy(busy), .issue_idx(issue_idx), .result_valid(result_valid),
    .result(result), .done(done)
  );

  flu_ctrl_sequencer #(.DEPTH(Depth), .AW(Aw), .HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .start(start1), .abort(1'b0), .result_in(result_in1),
    .control(control1), .busy(busy1), .issue_idx(issue_idx1), .result_valid(result_valid1),
    .result(result1), .done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = Aw'(a);
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " control"}, control, 32'h0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " issue_idx"}, issue_idx, '0);
    check({tag, " result_valid"}, result_valid, 1'b0);
    check({tag, " result"}, result, 32'h0);
    check({tag, " done"}, done, 1'b0);
  endtask

  // Runs n words from prog[]; optional mid-run write+start, abort or async reset at cycle t.
  task automatic run_prog(input int n, input int inj_t, input int abort_t, input int rst_t);
    int rv_seen;
    rv_seen = 0;
    prog_len = (Aw + 1)'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < n * Hold; t++) begin
      int k;
      int c;
      k = t / Hold;
      c = t % Hold;
      check("run control", control, prog[k].word);
      check("run issue_idx", issue_idx, k);
      check("run busy", busy, 1'b1);
      check("run done", done, 1'b0);
      check("run result_valid", result_valid, (c == 0 && k > 0));
      if (c == 0 && k > 0) check("run result", result, prog[k-1].resp);
      if (result_valid) rv_seen++;
      if (t == rst_t) begin
        #2 reset_n = 1'b0;
        #1 check_zero("async reset");
        step();
        check_zero("held reset");
        reset_n = 1'b1;
        return;
      end
      if (t == inj_t) begin
        wr_en = 1'b1;
        wr_addr = 1;
        wr_data = 32'hFFFF_FFFF;
        start = 1'b1;
      end
      if (t == abort_t) abort = 1'b1;
      step();
      wr_en = 1'b0;
      start = 1'b0;
      if (t == abort_t) begin
        abort = 1'b0;
        check("abort control", control, 32'h0);
        check("abort busy", busy, 1'b0);
        check("abort issue_idx", issue_idx, '0);
        check("abort result_valid", result_valid, 1'b0);
        check("abort done", done, 1'b0);
        check("abort results seen", rv_seen, 1);
        step();
        check("abort done later", done, 1'b0);
        return;
      end
    end
    check("end result_valid", result_valid, 1'b1);
    check("end result", result, prog[n-1].resp);
    check("end done", done, 1'b1);
    check("end busy", busy, 1'b0);
    check("end control", control, prog[n-1].word);
    check("end issue_idx", issue_idx, n - 1);
    step();
    check("post done", done, 1'b0);
    check("post result_valid", result_valid, 1'b0);
    check("post control", control, prog[n-1].word);
  endtask

  initial begin
    prog[0] = '{32'h0011_0FCB, 32'hFFEE_F034};
    prog[1] = '{32'h0832_0F4B, 32'hF7CD_F0B4};
    prog[2] = '{32'h1053_0ECB, 32'hEFAC_F134};
    prog[3] = '{32'h1895_0DCB, 32'hE76A_F234};
    for (int i = 0; i < 16; i++) words16[i] = 32'hA500_0000 | (i * 32'h0001_0203);

    // Reset asserted mid-cycle, before any clock edge.
    #3 reset_n = 1'b0;
    #1 check_zero("reset");
    check("reset busy1", busy1, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    step();

    prog_len = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("len0 done", done, 1'b1);
    check("len0 busy", busy, 1'b0);
    check("len0 control", control, 32'h0);
    step();
    check("len0 done pulse", done, 1'b0);
    check("len0 busy after", busy, 1'b0);

    for (int i = 0; i < 4; i++) write_word(i, prog[i].word);
    step();

    run_prog(4, -1, -1, -1);
    run_prog(4, 5, -1, -1);
    run_prog(4, -1, 15, -1);
    run_prog(4, -1, -1, -1);
    run_prog(4, -1, -1, 23);
    step();
    run_prog(4, -1, -1, -1);

    // Clamp to DEPTH with one-cycle hold on the second instance.
    for (int i = 0; i < 16; i++) write_word(i, words16[i]);
    prog_len = 20;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int t = 0; t < 16; t++) begin
      check("h1 control", control1, words16[t]);
      check("h1 issue_idx", issue_idx1, t);
      check("h1 busy", busy1, 1'b1);
      check("h1 done", done1, 1'b0);
      check("h1 result_valid", result_valid1, (t > 0));
      if (t > 0) check("h1 result", result1, ~words16[t-1]);
      step();
    end
    check("h1 end result_valid", result_valid1, 1'b1);
    check("h1 end result", result1, ~words16[15]);
    check("h1 end done", done1, 1'b1);
    check("h1 end busy", busy1, 1'b0);
    check("h1 end control", control1, words16[15]);
    step();
    check("h1 post done", done1, 1'b0);
    check("h1 post result_valid", result_valid1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
